// File: rtl/lab_counter4.sv
// Multi-mode 4-bit counter: binary up/down, self-correcting Johnson ring and
// maximal LFSR, with synchronous load, count enable and terminal-count flag.
module lab_counter4 #(
    parameter logic [3:0] RESET_VAL = 4'b0000,
    parameter logic [3:0] LFSR_SEED = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ld,
    input  logic [3:0] d,
    input  logic [1:0] mode,
    output logic [3:0] out,
    output logic       tc
);

    localparam int unsigned W = 4;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_JOHN = 2'b10;
    localparam logic [1:0] MODE_LFSR = 2'b11;

    localparam logic [W-1:0] TERM_UP   = 4'b1111;
    localparam logic [W-1:0] TERM_DOWN = 4'b0000;
    localparam logic [W-1:0] TERM_JOHN = 4'b1000;
    localparam logic [W-1:0] TERM_LFSR = 4'b1000;

    logic [W-1:0] nxt;
    logic [W-1:0] term;
    logic         john_legal;

    // Membership in the 8-state twisted ring; anything else is flushed to 0000
    always_comb begin
        john_legal = 1'b0;
        case (out)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: john_legal = 1'b1;
            default:                            john_legal = 1'b0;
        endcase
    end

    // Next value of the selected sequence, applied to the current out
    always_comb begin
        nxt = out;
        case (mode)
            MODE_UP:   nxt = W'(out + W'(1));
            MODE_DOWN: nxt = W'(out - W'(1));
            MODE_JOHN: nxt = john_legal ? {out[2:0], ~out[3]} : '0;
            MODE_LFSR: nxt = (out == '0) ? LFSR_SEED : {out[2:0], out[3] ^ out[2]};
            default:   nxt = out;
        endcase
    end

    always_comb begin
        term = TERM_UP;
        case (mode)
            MODE_UP:   term = TERM_UP;
            MODE_DOWN: term = TERM_DOWN;
            MODE_JOHN: term = TERM_JOHN;
            MODE_LFSR: term = TERM_LFSR;
            default:   term = TERM_UP;
        endcase
    end

    // Flags the last step before the sequence wraps; suppressed by reset and load
    assign tc = rst & en & ~ld & (out == term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= RESET_VAL;
        end else if (ld) begin
            out <= d;
        end else if (en) begin
            out <= nxt;
        end
    end

endmodule

// File: tb/tb_lab_counter4.sv
// Directed bench for lab_counter4: every sequence, wrap points, lock-up escape,
// async reset and control priority, against hand-computed values.
module tb_lab_counter4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ld;
    logic [3:0] d;
    logic [1:0] mode;
    logic [3:0] out;
    logic       tc;

    int total;
    int passed;

    lab_counter4 dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .ld   (ld),
        .d    (d),
        .mode (mode),
        .out  (out),
        .tc   (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b, expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    logic [3:0] john_seq [9];
    logic [3:0] lfsr_seq [15];

    initial begin
        total  = 0;
        passed = 0;
        john_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                     4'b1100, 4'b1000, 4'b0000, 4'b0001};
        lfsr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                     4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                     4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        rst  = 1'b1;
        en   = 1'b1;
        ld   = 1'b0;
        d    = 4'b0000;
        mode = 2'b00;

        // Reset state and tc masking while in reset
        #3 rst = 1'b0;
        #4;
        chk("reset_out", out, 4'b0000);
        chk("reset_tc", {3'b000, tc}, 4'b0000);
        @(posedge clk);
        #1;
        chk("reset_hold", out, 4'b0000);
        rst = 1'b1;
        chk("up_start_tc", {3'b000, tc}, 4'b0000);

        // Binary up, full cycle and wrap
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("up_out", out, 4'(i));
            chk("up_tc", {3'b000, tc}, (i == 15) ? 4'b0001 : 4'b0000);
        end
        tick();
        chk("up_wrap", out, 4'b0000);

        // Async reset mid-cycle at 0110
        for (int i = 0; i < 6; i++) tick();
        chk("up_at6", out, 4'b0110);
        rst = 1'b0;
        #1;
        chk("async_rst", out, 4'b0000);
        chk("async_rst_tc", {3'b000, tc}, 4'b0000);
        rst = 1'b1;
        tick();
        chk("resume", out, 4'b0001);

        // Binary down from reset
        do_reset();
        mode = 2'b01;
        #1;
        chk("down_start", out, 4'b0000);
        chk("down_tc0", {3'b000, tc}, 4'b0001);
        for (int i = 15; i >= 0; i--) begin
            tick();
            chk("down_out", out, 4'(i));
        end
        chk("down_tc_end", {3'b000, tc}, 4'b0001);

        // Johnson ring from reset
        do_reset();
        mode = 2'b10;
        #1;
        chk("john_tc0", {3'b000, tc}, 4'b0000);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("john_out", out, john_seq[i]);
            chk("john_tc", {3'b000, tc}, (john_seq[i] == 4'b1000) ? 4'b0001 : 4'b0000);
        end

        // Illegal Johnson load is accepted, then corrected
        ld = 1'b1; en = 1'b0; d = 4'b0101;
        tick();
        chk("john_ld", out, 4'b0101);
        ld = 1'b0; en = 1'b1;
        tick();
        chk("john_fix", out, 4'b0000);

        // LFSR from reset: lock-up escape then the 15-state period
        do_reset();
        mode = 2'b11;
        #1;
        chk("lfsr_start", out, 4'b0000);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("lfsr_out", out, lfsr_seq[i]);
            chk("lfsr_tc", {3'b000, tc}, (i == 14) ? 4'b0001 : 4'b0000);
        end
        tick();
        chk("lfsr_repeat", out, 4'b0001);

        // Loaded 0000 in LFSR mode escapes to seed
        ld = 1'b1; d = 4'b0000;
        tick();
        chk("lfsr_ld0", out, 4'b0000);
        ld = 1'b0;
        tick();
        chk("lfsr_seed", out, 4'b0001);

        // Hold with en=0
        mode = 2'b00;
        ld = 1'b1; d = 4'b0101;
        tick();
        ld = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_out", out, 4'b0101);
            chk("hold_tc", {3'b000, tc}, 4'b0000);
        end

        // Load wins over enable; tc masked by ld
        ld = 1'b1; en = 1'b1; d = 4'b1010;
        tick();
        chk("ld_pri", out, 4'b1010);
        d = 4'b1111;
        tick();
        chk("ld_1111", out, 4'b1111);
        chk("tc_ld_mask", {3'b000, tc}, 4'b0000);
        ld = 1'b0;
        #1;
        chk("tc_up_1111", {3'b000, tc}, 4'b0001);
        mode = 2'b01;
        #1;
        chk("tc_mode_sw", {3'b000, tc}, 4'b0000);

        // Mode switch up->down at 0100
        mode = 2'b00;
        ld = 1'b1; d = 4'b0100;
        tick();
        ld = 1'b0;
        mode = 2'b01;
        tick();
        chk("mode_sw", out, 4'b0011);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
